// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle mult/div engine owning the HI/LO registers
// One shift-add or restoring-divide iteration per cycle, followed by a sign-fixup cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mul0_div1_sel,
  input  logic             unsigned_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  input  logic             hilo_wr,
  input  logic             hi0_lo1_sel,
  input  logic [WIDTH-1:0] hilo_wd,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, low_q, low_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b, rem_sub;
  logic [WIDTH:0]     sum, rem_sh;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mag_a = (!unsigned_op && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b = (!unsigned_op && op_b[WIDTH-1]) ? -op_b : op_b;
    sum   = {1'b0, acc_q} + (low_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // acc holds the partial remainder, low shifts the dividend out and the quotient in
    rem_sh  = {acc_q, low_q[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, b_q};
    rem_sub = rem_sh[WIDTH-1:0] - b_q;
    prod    = {acc_q, low_q};

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    low_d   = low_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          low_d   = mag_a;
          b_d     = mag_b;
          div_d   = mul0_div1_sel;
          neg_d   = !unsigned_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          rneg_d  = !unsigned_op && op_a[WIDTH-1];
          dz_d    = mul0_div1_sel && (op_b == '0);
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (hilo_wr) begin
          if (hi0_lo1_sel) lo_d = hilo_wd;
          else             hi_d = hilo_wd;
        end
      end
      S_RUN: begin
        if (div_q) begin
          acc_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          low_d = {low_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_d = sum[WIDTH:1];
          low_d = {sum[0], low_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          // divide by zero: the remainder fixup restores op_a exactly
          lo_d = dz_q ? '1 : (neg_q ? -low_q : low_q);
          hi_d = rneg_q ? -acc_q : acc_q;
        end else begin
          {hi_d, lo_d} = neg_q ? -prod : prod;
        end
        cnt_d   = '0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      low_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      low_q   <= low_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign stall      = busy && (start || hilo_rd || hilo_wr);
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign hilo_rdata = hi0_lo1_sel ? lo_q : hi_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, mul0_div1_sel = 1'b0, unsigned_op = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, hilo_wd = '0;
  logic        hilo_rd = 1'b0, hilo_wr = 1'b0, hi0_lo1_sel = 1'b0;
  logic [31:0] hilo_rdata, hi, lo;
  logic        busy, done, stall;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic seen_done;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .mul0_div1_sel(mul0_div1_sel),
    .unsigned_op(unsigned_op), .op_a(op_a), .op_b(op_b), .hilo_rd(hilo_rd),
    .hilo_wr(hilo_wr), .hi0_lo1_sel(hi0_lo1_sel), .hilo_wd(hilo_wd),
    .hilo_rdata(hilo_rdata), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_op(input logic div, input logic uns, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; mul0_div1_sel = div; unsigned_op = uns; op_a = a; op_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(input string tag);
    while (!done && cyc < 60) step();
    chk({tag, "_latency"}, cyc, 34);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
  endtask

  initial begin
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    step(); step();
    rst = 1'b0;

    // idle mthi / mtlo and reads
    hilo_wr = 1'b1; hi0_lo1_sel = 1'b0; hilo_wd = 32'h0000_1234;
    step();
    chk("mthi", hi, 32'h0000_1234);
    hi0_lo1_sel = 1'b1; hilo_wd = 32'h0000_0055;
    step();
    hilo_wr = 1'b0;
    chk("mtlo", lo, 32'h0000_0055);
    hilo_rd = 1'b1; hi0_lo1_sel = 1'b0;
    #1;
    chk("mfhi_idle", hilo_rdata, 32'h0000_1234);
    chk("mfhi_idle_stall", {31'b0, stall}, 0);
    hilo_rd = 1'b0;

    // signed 7 * -3 with an mfhi waiting from cycle 3
    start_op(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD);
    step(); step();
    hilo_rd = 1'b1; hi0_lo1_sel = 1'b0;
    #1;
    chk("mfhi_stall_c3", {31'b0, stall}, 1);
    while (cyc < 33) step();
    chk("mfhi_stall_c33", {31'b0, stall}, 1);
    chk("mult_done_c33", {31'b0, done}, 0);
    step();
    chk("mult_done_c34", {31'b0, done}, 1);
    chk("mult_stall_c34", {31'b0, stall}, 0);
    chk("mult_rdata_c34", hilo_rdata, 32'hFFFF_FFFF);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    hilo_rd = 1'b0;
    step();
    chk("mult_done_pulse", {31'b0, done}, 0);

    // multu with an mtlo held while busy
    start_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    hilo_wr = 1'b1; hi0_lo1_sel = 1'b1; hilo_wd = 32'hDEAD_BEEF;
    #1;
    chk("mtlo_busy_stall", {31'b0, stall}, 1);
    wait_done("multu");
    hilo_wr = 1'b0;
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    start_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done("sdiv");
    chk("sdiv_lo", lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", hi, 32'hFFFF_FFFF);

    start_op(1'b1, 1'b1, 32'd100, 32'd0);
    wait_done("divu0");
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'h0000_0064);

    start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("ovf");
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);

    start_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0);
    wait_done("sdiv0");
    chk("sdiv0_lo", lo, 32'hFFFF_FFFF);
    chk("sdiv0_hi", hi, 32'hFFFF_FFF9);

    // back-to-back: new op issued in the done cycle
    start_op(1'b1, 1'b1, 32'd100, 32'd7);
    chk("b2b_busy", {31'b0, busy}, 1);
    wait_done("b2b");
    chk("b2b_lo", lo, 32'd14);
    chk("b2b_hi", hi, 32'd2);

    // start together with mthi: the write is dropped
    hilo_wr = 1'b1; hi0_lo1_sel = 1'b0; hilo_wd = 32'h0000_AAAA;
    start_op(1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3);
    hilo_wr = 1'b0;
    chk("start_wr_drop", hi, 32'd2);
    wait_done("mul_neg");
    chk("mul_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mul_neg_lo", lo, 32'hFFFF_FFFA);

    // reset in cycle 10 of a divide
    start_op(1'b1, 1'b1, 32'd1000, 32'd3);
    while (cyc < 10) step();
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", {31'b0, seen_done}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
